// File: rtl/obj_spawner.sv
// ---------------------------------------------------------------------------
// obj_spawner
//   Decides, at each new grid point the player crosses, whether to place an
//   object (coin, wall or turn) a fixed distance ahead. The object is held in
//   a one-entry output register and offered with a valid/ready handshake.
//   While an object is already held and not accepted, any new spawn is
//   discarded and counted.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   en           spawn enable (gates grid events only)
//   player_dist  player distance
//   rand_val     free-running random word
//   out_valid    object offered
//   out_ready    consumer accepts the offered object
//   out_obj      {lane[1:0], type[1:0], dist[DIST_W-1:0]}
//   drop_cnt     saturating count of objects lost to backpressure
// ---------------------------------------------------------------------------
module obj_spawner #(
  parameter int DIST_W       = 12,
  parameter int LOOKAHEAD    = 80,
  parameter int GRID_LOG2    = 3,
  parameter int SPAWN_THRESH = 128,
  parameter int WALL_THRESH  = 5,
  parameter int TURN_GAP     = 4,
  parameter int DROP_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DIST_W-1:0] player_dist,
  input  logic [19:0]       rand_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DIST_W+3:0] out_obj,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [1:0] TYPE_COIN  = 2'b00;
  localparam logic [1:0] TYPE_TURN  = 2'b01;
  localparam logic [1:0] TYPE_WALL  = 2'b10;

  localparam logic [1:0] LANE_LEFT  = 2'b10;
  localparam logic [1:0] LANE_MID   = 2'b00;
  localparam logic [1:0] LANE_RIGHT = 2'b01;

  localparam int CD_W = (TURN_GAP < 1) ? 1 : $clog2(TURN_GAP + 1);

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t            state, state_next;
  logic [DIST_W-1:0] prev_dist;
  logic [CD_W-1:0]   turn_cd;

  logic              grid_event;
  logic              spawn;
  logic              load;
  logic              drop;
  logic [1:0]        new_type;
  logic [1:0]        new_lane;
  logic [DIST_W-1:0] new_dist;

  // Bits of the random word this block does not consume.
  logic unused_rand;
  assign unused_rand = ^{rand_val[11:8], rand_val[4]};

  // A grid point counts once: the distance must have changed since last cycle.
  assign grid_event = en
                   && (player_dist[GRID_LOG2-1:0] == '0)
                   && (player_dist != prev_dist);

  // Threshold compared one bit wider so 256 means "always".
  assign spawn = grid_event
              && ({1'b0, rand_val[19:12]} < 9'(SPAWN_THRESH));

  // Distance wraps modulo 2^DIST_W.
  assign new_dist = player_dist + DIST_W'(LOOKAHEAD);

  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    new_type = TYPE_COIN;
    new_lane = LANE_MID;

    // A suppressed turn (cooldown active) falls through to the wall test.
    if ((rand_val[3:0] == 4'd0) && (turn_cd == '0)) begin
      new_type = TYPE_TURN;
    end else if (rand_val[3:0] < 4'(WALL_THRESH)) begin
      new_type = TYPE_WALL;
    end

    if (new_type == TYPE_TURN) begin
      new_lane = rand_val[5] ? LANE_LEFT : LANE_RIGHT;
    end else begin
      case (rand_val[7:5])
        3'd0, 3'd1, 3'd2: new_lane = LANE_LEFT;
        3'd3, 3'd4:       new_lane = LANE_MID;
        default:          new_lane = LANE_RIGHT;
      endcase
    end
  end

  // Controller: EMPTY/HOLD with a one-entry output register.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    drop       = 1'b0;
    case (state)
      EMPTY: begin
        if (spawn) begin
          load       = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (spawn) begin
          // Accepting this cycle frees the register for the new object.
          if (out_ready) load = 1'b1;
          else           drop = 1'b1;
        end else if (out_ready) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      prev_dist <= '0;
      out_obj   <= '0;
      drop_cnt  <= '0;
      turn_cd   <= '0;
    end else begin
      state     <= state_next;
      prev_dist <= player_dist;

      if (load) begin
        out_obj <= {new_lane, new_type, new_dist};
      end

      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end

      // Only a turn that actually reaches the output arms the cooldown.
      if (load && (new_type == TYPE_TURN)) begin
        turn_cd <= CD_W'(TURN_GAP);
      end else if (grid_event && (turn_cd != '0)) begin
        turn_cd <= turn_cd - 1'b1;
      end
    end
  end

  assign out_valid = (state == HOLD);

endmodule
